multiplier_arbiter: RTL

//  Shares one single-precision multiplier (stb/ack operand+result handshake) among NUM_REQ requesters.

---
 rtl/multiplier_arbiter_if.sv | 32 +++
 rtl/multiplier_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/multiplier_arbiter_if.sv
// Handshake bundle between the multiplier arbiter, its requesters and the shared multiplier.
// master: the arbiter's view. slave: the view of the requesters and the multiplier.
interface multiplier_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_stb;
  logic [NUM_REQ-1:0]    req_ack;
  logic [31:0]           res_z;
  logic [NUM_REQ-1:0]    res_stb;
  logic [NUM_REQ-1:0]    res_ack;
  logic [31:0]           mul_a;
  logic                  mul_a_stb;
  logic                  mul_a_ack;
  logic [31:0]           mul_b;
  logic                  mul_b_stb;
  logic                  mul_b_ack;
  logic [31:0]           mul_z;
  logic                  mul_z_stb;
  logic                  mul_z_ack;

  modport master (
    input  req_a, req_b, req_stb, res_ack, mul_a_ack, mul_b_ack, mul_z, mul_z_stb,
    output req_ack, res_z, res_stb, mul_a, mul_a_stb, mul_b, mul_b_stb, mul_z_ack
  );

  modport slave (
    output req_a, req_b, req_stb, res_ack, mul_a_ack, mul_b_ack, mul_z, mul_z_stb,
    input  req_ack, res_z, res_stb, mul_a, mul_a_stb, mul_b, mul_b_stb, mul_z_ack
  );
endinterface

// File: rtl/multiplier_arbiter.sv
// Round-robin sharing of one stb/ack single-precision multiplier among NUM_REQ requesters.
// Optional MULT_ARB_STATS_EN adds op_count (completed operations) and busy outputs.
module multiplier_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int GW      = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multiplier_arbiter_if.master   bus,
  output logic                   mul_rst,
  output logic [GW-1:0]          grant
`ifdef MULT_ARB_STATS_EN
  ,
  output logic [31:0]            op_count,
  output logic                   busy
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ACCEPT, ST_SEND_A, ST_SEND_B, ST_WAIT_Z, ST_RETURN
  } state_t;

  state_t               state_reg;
  logic [GW-1:0]        grant_reg;
  logic [NUM_REQ-1:0]   req_ack_reg;
  logic [NUM_REQ-1:0]   res_stb_reg;
  logic [31:0]          res_z_reg;
  logic [31:0]          mul_a_reg;
  logic [31:0]          mul_b_reg;
  logic                 mul_a_stb_reg;
  logic                 mul_b_stb_reg;
  logic                 mul_z_ack_reg;
  logic [1:0]           rst_pipe_reg;

  logic [31:0]          op_a [NUM_REQ];
  logic [31:0]          op_b [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign op_a[gi] = bus.req_a[32*gi +: 32];
    assign op_b[gi] = bus.req_b[32*gi +: 32];
  end

  // Round-robin search starting just after the last granted requester.
  logic [GW-1:0] pick;
  logic          found;
  always_comb begin
    pick  = grant_reg;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && bus.req_stb[GW'((int'(grant_reg) + k) % NUM_REQ)]) begin
        found = 1'b1;
        pick  = GW'((int'(grant_reg) + k) % NUM_REQ);
      end
    end
  end

  logic launch;
  logic abandon;
  logic done;
  assign launch  = (state_reg == ST_IDLE) && !mul_rst && found;
  assign abandon = (state_reg == ST_ACCEPT) && !bus.req_stb[grant_reg];
  assign done    = (state_reg == ST_RETURN) && bus.res_ack[grant_reg];

  // Multiplier reset follows rst_n asynchronously and releases two edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe_reg <= 2'b11;
    end else begin
      rst_pipe_reg <= {rst_pipe_reg[0], 1'b0};
    end
  end
  assign mul_rst = rst_pipe_reg[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      grant_reg     <= GW'(NUM_REQ - 1);
      req_ack_reg   <= '0;
      res_stb_reg   <= '0;
      res_z_reg     <= '0;
      mul_a_reg     <= '0;
      mul_b_reg     <= '0;
      mul_a_stb_reg <= 1'b0;
      mul_b_stb_reg <= 1'b0;
      mul_z_ack_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (launch) begin
            grant_reg   <= pick;
            req_ack_reg <= NUM_REQ'(1) << pick;
            state_reg   <= ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          req_ack_reg <= '0;
          if (abandon) begin
            state_reg <= ST_IDLE;
          end else begin
            // Both operands are captured now; mul_b stays unstrobed until a is taken.
            mul_a_reg     <= op_a[grant_reg];
            mul_b_reg     <= op_b[grant_reg];
            mul_a_stb_reg <= 1'b1;
            state_reg     <= ST_SEND_A;
          end
        end
        ST_SEND_A: begin
          if (bus.mul_a_ack) begin
            mul_a_stb_reg <= 1'b0;
            mul_b_stb_reg <= 1'b1;
            state_reg     <= ST_SEND_B;
          end
        end
        ST_SEND_B: begin
          if (bus.mul_b_ack) begin
            mul_b_stb_reg <= 1'b0;
            mul_z_ack_reg <= 1'b1;
            state_reg     <= ST_WAIT_Z;
          end
        end
        ST_WAIT_Z: begin
          if (bus.mul_z_stb) begin
            res_z_reg     <= bus.mul_z;
            mul_z_ack_reg <= 1'b0;
            res_stb_reg   <= NUM_REQ'(1) << grant_reg;
            state_reg     <= ST_RETURN;
          end
        end
        ST_RETURN: begin
          if (done) begin
            res_stb_reg <= '0;
            state_reg   <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign grant         = grant_reg;
  assign bus.req_ack   = req_ack_reg;
  assign bus.res_stb   = res_stb_reg;
  assign bus.res_z     = res_z_reg;
  assign bus.mul_a     = mul_a_reg;
  assign bus.mul_b     = mul_b_reg;
  assign bus.mul_a_stb = mul_a_stb_reg;
  assign bus.mul_b_stb = mul_b_stb_reg;
  assign bus.mul_z_ack = mul_z_ack_reg;

`ifdef MULT_ARB_STATS_EN
  logic [31:0] op_count_reg;
  logic        busy_reg;

  // busy tracks the state the FSM enters on this edge, so it is a plain register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_reg <= '0;
      busy_reg     <= 1'b0;
    end else begin
      if (done && op_count_reg != 32'hFFFF_FFFF) begin
        op_count_reg <= op_count_reg + 32'd1;
      end
      busy_reg <= !(((state_reg == ST_IDLE) && !launch) || abandon || done);
    end
  end

  assign op_count = op_count_reg;
  assign busy     = busy_reg;
`endif

endmodule
